// File: rtl/noc_vc_input_buffer_pkg.sv
// Shared definitions for the NoC VC input buffer: flit defaults, flit type field, clog2.
package noc_vc_input_buffer_pkg;

    localparam int unsigned FLIT_W_DEFAULT = 40;

    // Flit type field occupies the top FLIT_TYPE_W bits of a flit.
    localparam int unsigned FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FlitHead   = 2'd0,
        FlitBody   = 2'd1,
        FlitTail   = 2'd2,
        FlitSingle = 2'd3
    } flit_type_e;

    // Ceiling log2, used to derive VC and pointer widths from the counts.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_vc_input_buffer_vc_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for one virtual channel of the shared buffer.
module noc_vc_input_buffer_vc_fifo_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    // Pointers wrap modulo DEPTH; count only moves when exactly one of push/pop fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == FullCount);

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Multi-VC flit input buffer: NUM_VC FIFOs sharing one storage array, one credit per read.
module noc_vc_input_buffer
    import noc_vc_input_buffer_pkg::*;
#(
    parameter int unsigned FLIT_W = FLIT_W_DEFAULT,
    parameter int unsigned NUM_VC = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned VC_W   = clog2(NUM_VC),
    parameter int unsigned PTR_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [VC_W-1:0]   wr_vc,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [VC_W-1:0]   rd_vc,
    output logic [FLIT_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [NUM_VC-1:0] vc_empty,
    output logic [NUM_VC-1:0] vc_full,
    output logic [NUM_VC-1:0] credit_out,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int unsigned    MemDepth  = NUM_VC * DEPTH;
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]      wptr  [NUM_VC];
    logic [PTR_W-1:0]      rptr  [NUM_VC];
    logic [PTR_W:0]        count [NUM_VC];
    logic [NUM_VC-1:0]     empty;
    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     push;
    logic [NUM_VC-1:0]     pop;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [VC_W+PTR_W-1:0] wr_addr;
    logic [VC_W+PTR_W-1:0] rd_addr;
    logic [FLIT_W-1:0]     mem [MemDepth];

    // Write and read are accepted independently from pre-edge occupancy, so a full VC
    // never reuses a slot in the same cycle and an empty VC never falls through.
    assign wr_acc  = wr_en & ~full[wr_vc];
    assign rd_acc  = rd_en & ~empty[rd_vc];
    assign wr_addr = {wr_vc, wptr[wr_vc]};
    assign rd_addr = {rd_vc, rptr[rd_vc]};

    // Decode accepted requests into per-VC push/pop strobes.
    always_comb begin
        push = '0;
        pop  = '0;
        if (wr_acc) begin
            push[wr_vc] = 1'b1;
        end
        if (rd_acc) begin
            pop[rd_vc] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : gen_vc
        noc_vc_input_buffer_vc_fifo_ctrl #(
            .DEPTH (DEPTH),
            .PTR_W (PTR_W)
        ) u_ctrl (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .wptr  (wptr[g]),
            .rptr  (rptr[g]),
            .count (count[g]),
            .empty (empty[g]),
            .full  (full[g])
        );

        assign vc_empty[g] = (count[g] == '0);
        assign vc_full[g]  = (count[g] == FullCount);
    end

    // Shared storage; never reset, contents are only meaningful under a valid pointer.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, credit pulses and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            credit_out    <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rd_valid   <= rd_acc;
            credit_out <= pop;
            if (rd_acc) begin
                rd_data <= mem[rd_addr];
            end
            if (wr_en && full[wr_vc]) begin
                err_overflow <= 1'b1;
            end
            if (rd_en && empty[rd_vc]) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Self-checking bench for noc_vc_input_buffer with a per-VC queue scoreboard.
module tb_noc_vc_input_buffer;

    localparam int unsigned FLIT_W = 40;
    localparam int unsigned NUM_VC = 4;
    localparam int unsigned DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [1:0]        wr_vc;
    logic [FLIT_W-1:0] wr_data;
    logic              rd_en;
    logic [1:0]        rd_vc;
    logic [FLIT_W-1:0] rd_data;
    logic              rd_valid;
    logic [3:0]        vc_empty;
    logic [3:0]        vc_full;
    logic [3:0]        credit_out;
    logic              err_overflow;
    logic              err_underflow;

    int checks;
    int failures;
    int cred_cnt;
    int acc_reads;

    // Reference model state
    logic [FLIT_W-1:0] mq [NUM_VC][$];
    logic [FLIT_W-1:0] exp_q [$];
    logic              exp_valid;
    logic [3:0]        exp_credit;
    logic              m_ovf;
    logic              m_unf;

    noc_vc_input_buffer #(
        .FLIT_W (FLIT_W),
        .NUM_VC (NUM_VC),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_vc         (wr_vc),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_vc         (rd_vc),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .vc_empty      (vc_empty),
        .vc_full       (vc_full),
        .credit_out    (credit_out),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare outputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        logic [FLIT_W-1:0] d;
        logic [3:0]        m_empty;
        logic [3:0]        m_full;
        #1;
        for (int v = 0; v < NUM_VC; v++) begin
            m_empty[v] = (mq[v].size() == 0);
            m_full[v]  = (mq[v].size() == DEPTH);
        end
        cred_cnt = cred_cnt + $countones(credit_out);
        checks++;
        if (rd_valid !== exp_valid) begin
            failures++;
            $display("FAIL sb_rd_valid t=%0t got=%b exp=%b", $time, rd_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_queue t=%0t got=empty exp=entry", $time);
            end else begin
                d = exp_q.pop_front();
                if (rd_data !== d) begin
                    failures++;
                    $display("FAIL sb_rd_data t=%0t got=%h exp=%h", $time, rd_data, d);
                end
            end
        end
        checks++;
        if (credit_out !== exp_credit) begin
            failures++;
            $display("FAIL sb_credit t=%0t got=%b exp=%b", $time, credit_out, exp_credit);
        end
        checks++;
        if (vc_empty !== m_empty || vc_full !== m_full) begin
            failures++;
            $display("FAIL sb_flags t=%0t got empty=%b full=%b exp empty=%b full=%b",
                     $time, vc_empty, vc_full, m_empty, m_full);
        end
        checks++;
        if (err_overflow !== m_ovf || err_underflow !== m_unf) begin
            failures++;
            $display("FAIL sb_err t=%0t got ovf=%b unf=%b exp ovf=%b unf=%b",
                     $time, err_overflow, err_underflow, m_ovf, m_unf);
        end
    end

    // One clock of stimulus; model is advanced with pre-edge acceptance rules.
    task automatic cycle(input logic we, input logic [1:0] wv, input logic [FLIT_W-1:0] wd,
                         input logic re, input logic [1:0] rv);
        bit wacc;
        bit racc;
        wr_en   = we;
        wr_vc   = wv;
        wr_data = wd;
        rd_en   = re;
        rd_vc   = rv;
        wacc = we && (mq[wv].size() < DEPTH);
        racc = re && (mq[rv].size() != 0);
        if (we && !wacc) m_ovf = 1'b1;
        if (re && !racc) m_unf = 1'b1;
        exp_valid  = racc;
        exp_credit = racc ? (4'd1 << rv) : 4'd0;
        if (racc) begin
            exp_q.push_back(mq[rv].pop_front());
            acc_reads++;
        end
        if (wacc) mq[wv].push_back(wd);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic clear_model();
        for (int v = 0; v < NUM_VC; v++) mq[v].delete();
        exp_q.delete();
        exp_valid  = 1'b0;
        exp_credit = 4'd0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    task automatic apply_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear_model();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, FLIT_W'(40'h100 + i), 1'b0, 2'd0);
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd2);
        cycle(1'b1, 2'd1, FLIT_W'(40'h55), 1'b1, 2'd0);
        checks++;
        if (err_underflow !== 1'b1 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre got unf=%b valid=%b exp unf=1 valid=1",
                     err_underflow, rd_valid);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear_model();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (vc_empty !== 4'b1111 || vc_full !== 4'b0000 || rd_valid !== 1'b0 ||
            err_overflow !== 1'b0 || err_underflow !== 1'b0 || credit_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async got empty=%b full=%b valid=%b ovf=%b unf=%b cred=%b exp 1111/0000/0/0/0/0000",
                     vc_empty, vc_full, rd_valid, err_overflow, err_underflow, credit_out);
        end
        @(negedge clk);
        rst = 1'b0;
        // First read after reset must see the VC empty.
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
        checks++;
        if (rd_valid !== 1'b0 || err_underflow !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_read got valid=%b unf=%b exp valid=0 unf=1",
                     rd_valid, err_underflow);
        end
        apply_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 2'd2, FLIT_W'(i), 1'b0, 2'd0);
            checks++;
            if (vc_full[2] !== (i == 8)) begin
                failures++;
                $display("FAIL fill_full write=%0d got=%b exp=%b", i, vc_full[2], (i == 8));
            end
        end
        cycle(1'b1, 2'd2, FLIT_W'(40'hFF), 1'b0, 2'd0);
        checks++;
        if (err_overflow !== 1'b1 || vc_full[2] !== 1'b1) begin
            failures++;
            $display("FAIL fill_overflow got ovf=%b full=%b exp ovf=1 full=1",
                     err_overflow, vc_full[2]);
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1, 2'd2);
            checks++;
            if (rd_data !== FLIT_W'(i) || credit_out !== 4'b0100) begin
                failures++;
                $display("FAIL drain_read read=%0d got data=%h cred=%b exp data=%h cred=0100",
                         i, rd_data, credit_out, FLIT_W'(i));
            end
        end
        checks++;
        if (vc_empty[2] !== 1'b1 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got empty=%b unf=%b exp empty=1 unf=0",
                     vc_empty[2], err_underflow);
        end
        apply_reset();
    endtask

    task automatic test_interleave();
        cycle(1'b1, 2'd0, FLIT_W'(40'hA0), 1'b0, 2'd0);
        cycle(1'b1, 2'd3, FLIT_W'(40'hB0), 1'b0, 2'd0);
        cycle(1'b1, 2'd0, FLIT_W'(40'hA1), 1'b0, 2'd0);
        cycle(1'b1, 2'd3, FLIT_W'(40'hB1), 1'b0, 2'd0);
        checks++;
        if (vc_empty !== 4'b0110) begin
            failures++;
            $display("FAIL interleave_empty got=%b exp=0110", vc_empty);
        end
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd3);
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd3);
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
        checks++;
        if (rd_data !== FLIT_W'(40'hA0)) begin
            failures++;
            $display("FAIL interleave_vc0_first got=%h exp=a0", rd_data);
        end
        cycle(1'b0, 2'd0, '0, 1'b1, 2'd0);
        checks++;
        if (vc_empty !== 4'b1111) begin
            failures++;
            $display("FAIL interleave_drained got=%b exp=1111", vc_empty);
        end
        apply_reset();
    endtask

    task automatic test_simultaneous();
        int c0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd1, FLIT_W'(40'h200 + i), 1'b0, 2'd0);
        c0 = cred_cnt;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'd1, FLIT_W'(40'h300 + i), 1'b1, 2'd1);
        end
        checks++;
        if (cred_cnt - c0 != 10) begin
            failures++;
            $display("FAIL simul_credits got=%0d exp=10", cred_cnt - c0);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1, 2'd1);
            checks++;
            if (vc_empty[1] !== (i == 3)) begin
                failures++;
                $display("FAIL simul_count read=%0d got empty=%b exp=%b", i, vc_empty[1], (i == 3));
            end
        end
        checks++;
        if (rd_data !== FLIT_W'(40'h309)) begin
            failures++;
            $display("FAIL simul_last got=%h exp=309", rd_data);
        end
        apply_reset();
    endtask

    task automatic test_boundaries();
        cycle(1'b1, 2'd1, FLIT_W'(40'hC0), 1'b1, 2'd1);
        checks++;
        if (err_underflow !== 1'b1 || rd_valid !== 1'b0 || vc_empty[1] !== 1'b0) begin
            failures++;
            $display("FAIL bound_empty got unf=%b valid=%b empty=%b exp 1/0/0",
                     err_underflow, rd_valid, vc_empty[1]);
        end
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'd1, FLIT_W'(40'hD0 + i), 1'b0, 2'd0);
        cycle(1'b1, 2'd1, FLIT_W'(40'hEE), 1'b1, 2'd1);
        checks++;
        if (err_overflow !== 1'b1 || vc_full[1] !== 1'b0 || rd_data !== FLIT_W'(40'hD0)) begin
            failures++;
            $display("FAIL bound_full got ovf=%b full=%b data=%h exp 1/0/d0",
                     err_overflow, vc_full[1], rd_data);
        end
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b0, 2'd0, '0, 1'b1, 2'd1);
            checks++;
            if (vc_empty[1] !== (i == 7)) begin
                failures++;
                $display("FAIL bound_count read=%0d got empty=%b exp=%b", i, vc_empty[1], (i == 7));
            end
        end
        apply_reset();
    endtask

    task automatic test_random();
        int c0;
        int r0;
        c0 = cred_cnt;
        r0 = acc_reads;
        for (int i = 0; i < 5000; i++) begin
            cycle(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                  {8'($urandom), 32'($urandom)},
                  ($urandom_range(0, 9) < 5), 2'($urandom_range(0, 3)));
        end
        cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
        checks++;
        if ((cred_cnt - c0) != (acc_reads - r0) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_credits got=%0d exp=%0d pending=%0d",
                     cred_cnt - c0, acc_reads - r0, exp_q.size());
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cred_cnt  = 0;
        acc_reads = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_vc     = 2'd0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_vc     = 2'd0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_interleave();
        test_simultaneous();
        test_boundaries();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
